// File: rtl/step_debounce.sv
// Step/Peek pushbutton conditioner: synchronizers, Step press FSM with one-shot strobe,
// and an independent Peek level debouncer. Define STEP_AUTOREPEAT_EN to enable Step auto-repeat.
module step_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 25000000,
   parameter int unsigned REPEAT_CYCLES   = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_step_n,
   input  logic key_peek_n,
   output logic step,
   output logic peek_n,
   output logic step_held
);

   localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_ALL + 1) + 1;

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DEB_FULL = CW'(DEBOUNCE_CYCLES);
`ifdef STEP_AUTOREPEAT_EN
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_PRESS_CHK = 2'd1;
   localparam logic [1:0] S_HELD      = 2'd2;
   localparam logic [1:0] S_REL_CHK   = 2'd3;

   logic [1:0]    step_sync;
   logic [1:0]    peek_sync;
   logic          step_key_s;
   logic          peek_key_s;

   logic [1:0]    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          step_c;
   logic [CW-1:0] pcnt, pcnt_nx;
   logic          peek_nx;
`ifdef STEP_AUTOREPEAT_EN
   logic          rep, rep_nx;
`endif

   assign step_key_s = step_sync[1];
   assign peek_key_s = peek_sync[1];

   // Step FSM next state, shared debounce/hold counter, strobe request
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      step_c   = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
      rep_nx   = rep;
`endif
      case (state)
         S_IDLE: begin
            if (!step_key_s) begin
               state_nx = S_PRESS_CHK;
               cnt_nx   = '0;
            end
         end
         S_PRESS_CHK: begin
            if (step_key_s) begin
               state_nx = S_IDLE;
            end else if (cnt == DEB_LAST) begin
               state_nx = S_HELD;
               cnt_nx   = '0;
               step_c   = 1'b1;
`ifdef STEP_AUTOREPEAT_EN
               rep_nx   = 1'b0;
`endif
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_HELD: begin
            if (step_key_s) begin
               state_nx = S_REL_CHK;
               cnt_nx   = '0;
            end
`ifdef STEP_AUTOREPEAT_EN
            // first repeat after the hold time, then one per repeat period
            else if (cnt == (rep ? REP_LAST : HOLD_LAST)) begin
               step_c = 1'b1;
               cnt_nx = '0;
               rep_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
`endif
         end
         S_REL_CHK: begin
            if (!step_key_s) begin
               state_nx = S_HELD;
               cnt_nx   = '0;
`ifdef STEP_AUTOREPEAT_EN
               rep_nx   = 1'b0;
`endif
            end else if (cnt == DEB_LAST) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Peek level debouncer; the extra count aligns its latency with the Step strobe
   always_comb begin
      peek_nx = peek_n;
      pcnt_nx = '0;
      if (peek_key_s != peek_n) begin
         if (pcnt == DEB_FULL) begin
            peek_nx = peek_key_s;
         end else begin
            pcnt_nx = pcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_sync <= 2'b11;
         peek_sync <= 2'b11;
         state     <= S_IDLE;
         cnt       <= '0;
         pcnt      <= '0;
         step      <= 1'b0;
         peek_n    <= 1'b1;
         step_held <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
         rep       <= 1'b0;
`endif
      end else begin
         step_sync <= {step_sync[0], key_step_n};
         peek_sync <= {peek_sync[0], key_peek_n};
         state     <= state_nx;
         cnt       <= cnt_nx;
         pcnt      <= pcnt_nx;
         step      <= step_c;
         peek_n    <= peek_nx;
         step_held <= (state_nx == S_HELD) || (state_nx == S_REL_CHK);
`ifdef STEP_AUTOREPEAT_EN
         rep       <= rep_nx;
`endif
      end
   end

endmodule

// File: doc/step_debounce.md
STEP_DEBOUNCE -- requirements
Module: step_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable synchronized cycles required to accept a level change (10 ms at 50 MHz); legal range is at least 2.
REQ-002 Parameter HOLD_CYCLES, default 25000000, cycles the Step key is held in HELD before auto-repeat begins (used only with STEP_AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_CYCLES, default 5000000, cycles between auto-repeat pulses (used only with STEP_AUTOREPEAT_EN).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 key_step_n  input  1  raw asynchronous Step pushbutton (KEY0), low = pressed.
REQ-007 key_peek_n  input  1  raw asynchronous Peek pushbutton (KEY1), low = pressed.
REQ-008 step  output  1  single-cycle step strobe, consumed by the peek/display harness and the CPU step enable.
REQ-009 peek_n  output  1  debounced Peek level, low = pressed, consumed directly as the harness Peek input.
REQ-010 step_held  output  1  high while the Step FSM is in HELD or REL_CHK.

Function
REQ-011 Each raw key passes through its own two-flop synchronizer; key_s denotes the second flop.
REQ-012 Step FSM states: IDLE, PRESS_CHK, HELD, REL_CHK; one debounce counter, wide enough for max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).
REQ-013 IDLE: key_s=0 -> PRESS_CHK with counter cleared; otherwise remain in IDLE.
REQ-014 PRESS_CHK: key_s=1 -> IDLE (bounce rejected, no strobe); key_s=0 increments the counter; reaching DEBOUNCE_CYCLES-1 -> HELD and asserts step for exactly that one transition cycle.
REQ-015 Latency: with key_step_n first sampled low at edge 0 and held low, step is high for exactly the cycle following edge DEBOUNCE_CYCLES+2.
REQ-016 HELD: key_s=1 -> REL_CHK with counter cleared; no strobes are issued in HELD except by REQ-025.
REQ-017 REL_CHK: key_s=0 -> HELD (release bounce rejected, no new strobe); key_s=1 held until the counter reaches DEBOUNCE_CYCLES-1 -> IDLE.
REQ-018 step never stays high for two consecutive cycles; a new press after IDLE produces exactly one strobe.
REQ-019 Peek channel: an independent stable-level debouncer; peek_n changes to key_s only after key_s has differed from peek_n for DEBOUNCE_CYCLES consecutive cycles, with the count cleared on any agreeing cycle.
REQ-020 The Peek update has the same latency as REQ-015, applied to both edges.
REQ-021 The two channels are fully independent; simultaneous presses produce both a strobe and a peek_n transition, each at its own nominal latency.

Reset
REQ-022 While reset is sampled high:
- synchronizer flops = 1
- Step FSM = IDLE, counters = 0
- step = 0, peek_n = 1, step_held = 0
REQ-023 Reset mid-debounce or mid-hold aborts the sequence with no strobe; a key still low after reset deasserts is re-qualified from zero and yields one strobe per REQ-015, measured from the first edge after reset.

Configuration
REQ-024 Macro STEP_AUTOREPEAT_EN selects auto-repeat.
REQ-025 With STEP_AUTOREPEAT_EN defined:
- after HOLD_CYCLES continuous cycles in HELD, step pulses once;
- step then pulses every REPEAT_CYCLES cycles until the FSM leaves HELD;
- REL_CHK pauses the repeat timer, and a return to HELD restarts it at 0.
REQ-026 With STEP_AUTOREPEAT_EN undefined, exactly one strobe is issued per accepted press regardless of hold length, and HOLD_CYCLES and REPEAT_CYCLES are unused.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-027 Clean press: key_step_n low at edge 0, held 40 cycles -> step high only in the cycle after edge 6; without the macro there is no further strobe.
REQ-028 Bounce: key_step_n low 2 cycles, high 1, low 2, high -> step never asserted; FSM returns to IDLE.
REQ-029 Release bounce: after an accepted press, key high 2 cycles, low 3, high 10 -> no second strobe; step_held falls once, 4 stable-high cycles after the final rise.
REQ-030 Auto-repeat (macro defined): press held 60 cycles -> strobes at the press strobe, then +20, +28, +36, +44, +52 cycles after entering HELD.
REQ-031 Peek plus reset: key_peek_n low 10 cycles -> peek_n falls after edge 6; assert reset with the key still low -> peek_n=1 immediately, falls again 6 edges after reset release.
REQ-032 Simultaneous: both keys pressed at edge 0 -> step strobe and peek_n fall occur in the same cycle.
